// File: rtl/unidade_despacho_pkg.sv
// Shared encodings for the issue controller: opcodes, functional-unit classes and FSM states.
package pkg_despacho;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_ST  = 4'd5;

  typedef enum logic [1:0] {CLS_ALU, CLS_MUL, CLS_MEM, CLS_NONE} classe_t;

  typedef enum logic [1:0] {IDLE, POP, DECODE, ISSUE} estado_t;

  // NOP and illegal opcodes both map to CLS_NONE; the caller tells them apart.
  function automatic classe_t decodifica(input logic [3:0] op);
    classe_t c;
    case (op)
      OP_ADD, OP_SUB: c = CLS_ALU;
      OP_MUL:         c = CLS_MUL;
      OP_LD, OP_ST:   c = CLS_MEM;
      default:        c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_despacho_seletor_rr.sv
// Round-robin free-station picker: first non-busy index at or after ptr_i, wrapping modulo N.
module seletor_rr #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]                     busy_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                     grant_o,
  output logic                             found_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr_i) + k) % N);
      if (!found_o && !busy_i[idx]) begin
        grant_o[idx] = 1'b1;
        found_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unidade_despacho.sv
// In-order issue controller: pops the instruction queue, decodes the class and issues
// to a free reservation station chosen round-robin, honouring Stall back-pressure.
module unidade_despacho
  import pkg_despacho::*;
#(
  parameter int unsigned N_ALU = 3,
  parameter int unsigned N_MUL = 2,
  parameter int unsigned N_MEM = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      Instrucao,
  input  logic             Empty,
  input  logic             Stall,
  input  logic [N_ALU-1:0] Busy_ALU,
  input  logic [N_MUL-1:0] Busy_MUL,
  input  logic [N_MEM-1:0] Busy_MEM,
  output logic             Pop,
  output logic [N_ALU-1:0] Emite_ALU,
  output logic [N_MUL-1:0] Emite_MUL,
  output logic [N_MEM-1:0] Emite_MEM,
  output logic [3:0]       Opcode,
  output logic [3:0]       Rd,
  output logic [3:0]       Rs,
  output logic [3:0]       Rt,
  output logic             Ilegal,
  output logic [7:0]       Emitidas
);

  localparam int unsigned PW_ALU = (N_ALU > 1) ? $clog2(N_ALU) : 1;
  localparam int unsigned PW_MUL = (N_MUL > 1) ? $clog2(N_MUL) : 1;
  localparam int unsigned PW_MEM = (N_MEM > 1) ? $clog2(N_MEM) : 1;

  estado_t           estado_q, estado_d;
  classe_t           cls_q, cls_d;
  logic [3:0]        op_q, op_d, rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [7:0]        cont_q, cont_d;
  logic [PW_ALU-1:0] ptr_alu_q, ptr_alu_d;
  logic [PW_MUL-1:0] ptr_mul_q, ptr_mul_d;
  logic [PW_MEM-1:0] ptr_mem_q, ptr_mem_d;

  logic [N_ALU-1:0]  gnt_alu;
  logic [N_MUL-1:0]  gnt_mul;
  logic [N_MEM-1:0]  gnt_mem;
  logic              achou_alu, achou_mul, achou_mem, pronto;

  seletor_rr #(.N(N_ALU)) u_sel_alu (
    .busy_i(Busy_ALU), .ptr_i(ptr_alu_q), .grant_o(gnt_alu), .found_o(achou_alu)
  );
  seletor_rr #(.N(N_MUL)) u_sel_mul (
    .busy_i(Busy_MUL), .ptr_i(ptr_mul_q), .grant_o(gnt_mul), .found_o(achou_mul)
  );
  seletor_rr #(.N(N_MEM)) u_sel_mem (
    .busy_i(Busy_MEM), .ptr_i(ptr_mem_q), .grant_o(gnt_mem), .found_o(achou_mem)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q  <= IDLE;
      cls_q     <= CLS_NONE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      cont_q    <= '0;
      ptr_alu_q <= '0;
      ptr_mul_q <= '0;
      ptr_mem_q <= '0;
    end else begin
      estado_q  <= estado_d;
      cls_q     <= cls_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      cont_q    <= cont_d;
      ptr_alu_q <= ptr_alu_d;
      ptr_mul_q <= ptr_mul_d;
      ptr_mem_q <= ptr_mem_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cls_d     = cls_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    cont_d    = cont_q;
    ptr_alu_d = ptr_alu_q;
    ptr_mul_d = ptr_mul_q;
    ptr_mem_d = ptr_mem_q;
    Pop       = 1'b0;
    Ilegal    = 1'b0;
    Emite_ALU = '0;
    Emite_MUL = '0;
    Emite_MEM = '0;

    case (cls_q)
      CLS_ALU: pronto = achou_alu;
      CLS_MUL: pronto = achou_mul;
      CLS_MEM: pronto = achou_mem;
      default: pronto = 1'b0;
    endcase

    case (estado_q)
      IDLE: if (!Empty) estado_d = POP;
      POP: begin
        Pop      = 1'b1;
        estado_d = DECODE;
      end
      DECODE: begin
        op_d  = Instrucao[15:12];
        rd_d  = Instrucao[11:8];
        rs_d  = Instrucao[7:4];
        rt_d  = Instrucao[3:0];
        cls_d = decodifica(Instrucao[15:12]);
        if (Instrucao[15:12] == OP_NOP) begin
          estado_d = IDLE;
        end else if (decodifica(Instrucao[15:12]) == CLS_NONE) begin
          Ilegal   = 1'b1;
          estado_d = IDLE;
        end else begin
          estado_d = ISSUE;
        end
      end
      ISSUE: begin
        // Grant is combinational on this cycle's Busy/Stall; otherwise hold here.
        if (!Stall && pronto) begin
          case (cls_q)
            CLS_ALU: begin
              Emite_ALU = gnt_alu;
              for (int unsigned k = 0; k < N_ALU; k++)
                if (gnt_alu[k]) ptr_alu_d = PW_ALU'((k + 1) % N_ALU);
            end
            CLS_MUL: begin
              Emite_MUL = gnt_mul;
              for (int unsigned k = 0; k < N_MUL; k++)
                if (gnt_mul[k]) ptr_mul_d = PW_MUL'((k + 1) % N_MUL);
            end
            CLS_MEM: begin
              Emite_MEM = gnt_mem;
              for (int unsigned k = 0; k < N_MEM; k++)
                if (gnt_mem[k]) ptr_mem_d = PW_MEM'((k + 1) % N_MEM);
            end
            default: ;
          endcase
          cont_d   = cont_q + 8'd1;
          estado_d = Empty ? IDLE : POP;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  assign Opcode   = op_q;
  assign Rd       = rd_q;
  assign Rs       = rs_q;
  assign Rt       = rt_q;
  assign Emitidas = cont_q;

endmodule

// File: tb/tb_unidade_despacho.sv
// Scoreboard bench for unidade_despacho: a falling-edge queue model feeds the DUT,
// expected issues are queued at push time and checked by an independent monitor.
module tb_unidade_despacho;

  localparam int NA = 3;
  localparam int NM = 2;
  localparam int NE = 2;

  logic          Clock = 1'b0;
  logic          Reset, Empty, Stall, Pop, Ilegal;
  logic [15:0]   Instrucao;
  logic [NA-1:0] Busy_ALU, Emite_ALU;
  logic [NM-1:0] Busy_MUL, Emite_MUL;
  logic [NE-1:0] Busy_MEM, Emite_MEM;
  logic [3:0]    Opcode, Rd, Rs, Rt;
  logic [7:0]    Emitidas;

  always #5 Clock = ~Clock;

  unidade_despacho #(.N_ALU(NA), .N_MUL(NM), .N_MEM(NE)) dut (
    .Clock(Clock), .Reset(Reset), .Instrucao(Instrucao), .Empty(Empty), .Stall(Stall),
    .Busy_ALU(Busy_ALU), .Busy_MUL(Busy_MUL), .Busy_MEM(Busy_MEM), .Pop(Pop),
    .Emite_ALU(Emite_ALU), .Emite_MUL(Emite_MUL), .Emite_MEM(Emite_MEM),
    .Opcode(Opcode), .Rd(Rd), .Rs(Rs), .Rt(Rt), .Ilegal(Ilegal), .Emitidas(Emitidas)
  );

  typedef struct {
    bit          ileg;
    int          cls;
    logic [15:0] ins;
  } exp_t;

  logic [15:0]   fq[$];
  exp_t          sb[$];
  logic [NA-1:0] alu_log[$];
  logic [NM-1:0] mul_log[$];
  logic [NE-1:0] mem_log[$];

  int checks = 0, passes = 0;
  int ptr[3];
  int cnt = 0;
  int cyc = 0, pop_cnt = 0, emit_cnt = 0, ileg_cnt = 0;
  int last_pop_cyc = 0, last_emit_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic push(input logic [15:0] ins);
    exp_t e;
    int op;
    op = int'(ins[15:12]);
    fq.push_back(ins);
    Empty = 1'b0;
    if (op == 0) return;
    e.ins  = ins;
    e.ileg = (op > 5);
    e.cls  = (op <= 2) ? 0 : (op == 3) ? 1 : 2;
    sb.push_back(e);
  endtask

  function automatic int pick(input int c);
    int n;
    logic [7:0] b;
    n = (c == 0) ? NA : (c == 1) ? NM : NE;
    b = (c == 0) ? 8'(Busy_ALU) : (c == 1) ? 8'(Busy_MUL) : 8'(Busy_MEM);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr[c] + k) % n;
      if (!b[i]) return i;
    end
    return -1;
  endfunction

  // Instruction queue: presents the popped head on the falling edge after Pop.
  always @(negedge Clock) begin
    if (Pop === 1'b1 && Reset === 1'b0) begin
      chk("pop_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() > 0) Instrucao = fq.pop_front();
    end
    Empty = (fq.size() == 0);
  end

  initial begin : monitor
    exp_t e;
    int nh, idx, n;
    logic [7:0] gv;
    forever begin
      @(negedge Clock);
      #2;
      cyc++;
      if (Reset !== 1'b0) begin
        for (int c = 0; c < 3; c++) ptr[c] = 0;
        cnt = 0;
        sb.delete();
        continue;
      end
      chk("emitidas", 32'(Emitidas), 32'(cnt));
      if (Pop) begin
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      nh = $countones({Emite_ALU, Emite_MUL, Emite_MEM});
      if (nh != 0) begin
        emit_cnt++;
        last_emit_cyc = cyc;
        if (Emite_ALU != 0) alu_log.push_back(Emite_ALU);
        if (Emite_MUL != 0) mul_log.push_back(Emite_MUL);
        if (Emite_MEM != 0) mem_log.push_back(Emite_MEM);
        chk("onehot", 32'(nh), 32'd1);
        chk("no_issue_under_stall", 32'(Stall), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_issue", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("issue_kind", 32'(e.ileg), 32'd0);
          chk("class", (Emite_ALU != 0) ? 32'd0 : (Emite_MUL != 0) ? 32'd1 : 32'd2, 32'(e.cls));
          chk("fields", {16'd0, Opcode, Rd, Rs, Rt}, {16'd0, e.ins});
          idx = pick(e.cls);
          n   = (e.cls == 0) ? NA : (e.cls == 1) ? NM : NE;
          gv  = (e.cls == 0) ? 8'(Emite_ALU) : (e.cls == 1) ? 8'(Emite_MUL) : 8'(Emite_MEM);
          chk("grant", 32'(gv), (idx < 0) ? 32'd0 : (32'd1 << idx));
          if (idx >= 0) ptr[e.cls] = (idx + 1) % n;
        end
        cnt = (cnt + 1) % 256;
      end
      if (Ilegal) begin
        ileg_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_ilegal", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ilegal_kind", 32'(e.ileg), 32'd1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    Stall = 1'b1;
    fq.delete();
    Empty = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_pop", 32'(Pop), 32'd0);
    chk("rst_emite", 32'({Emite_ALU, Emite_MUL, Emite_MEM}), 32'd0);
    chk("rst_ilegal", 32'(Ilegal), 32'd0);
    chk("rst_fields", 32'({Opcode, Rd, Rs, Rt}), 32'd0);
    chk("rst_emitidas", 32'(Emitidas), 32'd0);
    Reset = 1'b0;
    Stall = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((fq.size() != 0 || sb.size() != 0) && n < maxc) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_done", 32'(fq.size() == 0 && sb.size() == 0), 32'd1);
    repeat (4) @(negedge Clock);
  endtask

  initial begin : main
    int e0, p0, i0, c;
    Reset = 1'b1; Stall = 1'b0; Empty = 1'b1; Instrucao = '0;
    Busy_ALU = '0; Busy_MUL = '0; Busy_MEM = '0;

    // Single ADD: Pop once, issue two cycles later to station 0.
    do_reset();
    @(negedge Clock);
    push(16'h1123);
    drain(50);
    chk("t1_pop_once", 32'(pop_cnt), 32'd1);
    chk("t1_latency", 32'(last_emit_cyc - last_pop_cyc), 32'd2);
    chk("t1_grant", 32'(alu_log.size() > 0 ? alu_log[0] : 3'b000), 32'b001);
    chk("t1_regs", 32'({Rd, Rs, Rt}), 32'h123);
    chk("t1_emitidas", 32'(Emitidas), 32'd1);

    // Round robin over free ALU stations, wrapping on the fourth.
    do_reset();
    alu_log.delete();
    @(negedge Clock);
    push(16'h1111); push(16'h2222); push(16'h1333); push(16'h1444);
    drain(60);
    chk("t2_count", 32'(alu_log.size()), 32'd4);
    if (alu_log.size() == 4) begin
      chk("t2_g0", 32'(alu_log[0]), 32'b001);
      chk("t2_g1", 32'(alu_log[1]), 32'b010);
      chk("t2_g2", 32'(alu_log[2]), 32'b100);
      chk("t2_g3", 32'(alu_log[3]), 32'b001);
    end

    // MUL held by busy stations, then released.
    Busy_MUL = 2'b11;
    e0 = emit_cnt; p0 = pop_cnt;
    push(16'h3456);
    repeat (3) @(negedge Clock);
    repeat (5) @(negedge Clock);
    chk("t3_no_issue", 32'(emit_cnt), 32'(e0));
    chk("t3_no_pop", 32'(pop_cnt), 32'(p0 + 1));
    @(negedge Clock);
    Busy_MUL = 2'b10;
    #3 c = cyc;
    drain(20);
    chk("t3_issue_cycle", 32'(last_emit_cyc), 32'(c));
    chk("t3_grant", 32'(mul_log.size() > 0 ? mul_log[mul_log.size()-1] : 2'b00), 32'b01);
    Busy_MUL = '0;

    // LD blocked by Stall with free stations.
    Stall = 1'b1;
    e0 = emit_cnt;
    push(16'h4789);
    repeat (7) @(negedge Clock);
    chk("t4_no_issue", 32'(emit_cnt), 32'(e0));
    Stall = 1'b0;
    #3 c = cyc;
    drain(20);
    chk("t4_issue_cycle", 32'(last_emit_cyc), 32'(c));
    chk("t4_grant", 32'(mem_log.size() > 0 ? mem_log[mem_log.size()-1] : 2'b00), 32'b01);

    // NOP is silent; opcode 15 pulses Ilegal once.
    e0 = emit_cnt; i0 = ileg_cnt;
    push(16'h0000);
    push(16'hF123);
    drain(30);
    chk("t5_ilegal_once", 32'(ileg_cnt), 32'(i0 + 1));
    chk("t5_no_issue", 32'(emit_cnt), 32'(e0));
    chk("t5_emitidas", 32'(Emitidas), 32'd6);

    // Reset while stuck in ISSUE drops the instruction.
    Busy_ALU = 3'b111;
    e0 = emit_cnt;
    push(16'h1abc);
    repeat (6) @(negedge Clock);
    do_reset();
    Busy_ALU = '0;
    repeat (5) @(negedge Clock);
    chk("t6_dropped", 32'(emit_cnt), 32'(e0));

    // Counter wrap after 256 issues.
    e0 = emit_cnt;
    for (int k = 0; k < 256; k++) push({4'(1 + k % 5), 12'(k)});
    drain(900);
    chk("t7_issues", 32'(emit_cnt - e0), 32'd256);
    chk("t7_wrap", 32'(Emitidas), 32'd0);

    // Random traffic with random busy/stall.
    for (int k = 0; k < 3000; k++) begin
      @(negedge Clock);
      Stall    = ($urandom_range(0, 3) == 0);
      Busy_ALU = NA'($urandom);
      Busy_MUL = NM'($urandom);
      Busy_MEM = NE'($urandom);
      if (fq.size() < 3 && $urandom_range(0, 2) == 0) begin
        logic [3:0] op;
        op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
        push({op, 12'($urandom)});
      end
    end
    @(negedge Clock);
    Stall = 1'b0; Busy_ALU = '0; Busy_MUL = '0; Busy_MEM = '0;
    drain(200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
